// File: rtl/program_loader.sv
// Packs 32-bit instruction words from a valid/ready stream into a flat program bus.
// Slot 0 is filled first. Loading stops at a zero (halt) word or once every slot is full.
module program_loader #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic [WORD_WIDTH-1:0]       in_word,
    output logic                        in_ready,
    output logic [WORD_WIDTH*DEPTH-1:0] program_address_array,
    output logic [$clog2(DEPTH+1)-1:0]  word_count,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [WORD_WIDTH*DEPTH-1:0] array_q, array_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        overrun_q, overrun_d;
    logic                        in_ready_q, busy_q, done_q;

    always_comb begin
        state_d   = state_q;
        array_d   = array_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        // start takes priority over any handshake or overrun in the same cycle
        if (start) begin
            array_d   = '0;
            count_d   = '0;
            overrun_d = 1'b0;
            state_d   = S_LOAD;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        for (int unsigned k = 0; k < DEPTH; k++) begin
                            if (count_q == CNT_W'(k)) begin
                                array_d[k*WORD_WIDTH +: WORD_WIDTH] = in_word;
                            end
                        end
                        count_d = count_q + 1'b1;
                        if (in_word == '0 || count_q == CNT_W'(DEPTH - 1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (in_valid && in_word != '0) begin
                        overrun_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Status outputs are registered from the next state, so they track the state flop exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            array_q    <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            array_q    <= array_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            in_ready_q <= (state_d == S_LOAD);
            busy_q     <= (state_d == S_LOAD);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign in_ready              = in_ready_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign overrun               = overrun_q;
    assign word_count            = count_q;
    assign program_address_array = array_q;

endmodule
